// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Word-organised data memory that responds to the core's load/store
// request/response interface. It takes one request at a time, waits LATENCY
// cycles, commits (byte-masked store or full-word load), and then holds the
// response until the requester accepts it.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   LATENCY      wait cycles between acceptance and commit (0..15)
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   : req_addr >= 4*DEPTH_WORDS faults (rsp_err=1, no write)
//   undefined : upper address bits ignored, word index wraps
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_we/addr/wdata/be          request payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            response payload
//   dbg_state                     current FSM state (0=IDLE, 1=WAIT, 2=RESP)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The request side only asserts req_ready in IDLE; the response side holds
// rsp_valid, rsp_rdata and rsp_err stable until rsp_ready is seen.
// -----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Commit operands: with LATENCY=0 the commit happens on the acceptance
    // edge, so the live request is used; otherwise the captured copy.
    logic             cmt_sel_live;
    logic             cmt_we;
    logic [31:0]      cmt_addr;
    logic [31:0]      cmt_wdata;
    logic [3:0]       cmt_be;
    logic [IDX_W-1:0] cmt_idx;
    logic             cmt_fault;
    logic             commit;
    logic             accept;
    logic             mem_we;

    assign accept       = req_valid && req_ready_q && (state_q == ST_IDLE);
    assign cmt_sel_live = (state_q == ST_IDLE);
    assign cmt_we       = cmt_sel_live ? req_we    : we_q;
    assign cmt_addr     = cmt_sel_live ? req_addr  : addr_q;
    assign cmt_wdata    = cmt_sel_live ? req_wdata : wdata_q;
    assign cmt_be       = cmt_sel_live ? req_be    : be_q;
    assign cmt_idx      = cmt_addr[IDX_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign cmt_fault = (cmt_addr[1:0] != 2'b00) ||
                       ((cmt_addr >> (IDX_W + 2)) != 32'd0);
`else
    assign cmt_fault = (cmt_addr[1:0] != 2'b00);
`endif

    // Upper address bits are only consulted by the bounds check.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, cmt_addr[31:IDX_W+2]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Also raises req_ready on the first edge out of reset.
                req_ready_d = !accept;
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (LATENCY == 0) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d   = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b0;
            end
        endcase

        if (commit) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = cmt_fault;
            // Load data is the word before any write in this edge; stores
            // and faults return zero.
            rsp_rdata_d = (!cmt_we && !cmt_fault) ? mem_q[cmt_idx] : 32'd0;
        end
    end

    assign mem_we = commit && cmt_we && !cmt_fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is deliberately not reset; commit never fires during reset
    // because the FSM is held in IDLE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && cmt_be[i]) begin
                mem_q[cmt_idx][8*i +: 8] <= cmt_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    // Three instances: index 0 LATENCY=1, index 1 LATENCY=0, index 2 LATENCY=4.
    logic        clk;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic [1:0]  dbg_state [3];

    int checks = 0;
    int errors = 0;

    data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
    );

    data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
    );

    data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset_n(rst_n[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .dbg_state(dbg_state[2])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Full transaction with rsp_ready held high. Called at a negedge;
    // returns at a negedge after the response handshake.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rdata, output logic err, output int lat);
        int n;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[d] && lat < 40);
        chk("rsp_valid_seen", 32'(rsp_valid[d]), 32'd1);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];
    int   nvec;

    task automatic add(input string nm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] er, input logic ee);
        vecs[nvec] = '{nm, we, addr, wdata, be, er, ee};
        nvec++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_be[d] = 4'd0;
            rsp_ready[d] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
        chk("rst_state",     32'(dbg_state[0]), 32'd0);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        #1;
        chk("rel_req_ready_before_edge", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        chk("rel_req_ready_after_edge", 32'(req_ready[0]), 32'd1);

        // Directed table on the LATENCY=1 instance
        nvec = 0;
        add("st_full_10",   1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        add("ld_10",        1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        add("st_be5_10",    1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0);
        add("ld_10_be5",    1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0);
        add("st_be0_10",    1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
        add("ld_10_be0",    1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0);
        add("ld_mis_13",    1'b0, 32'h13,   32'h0,        4'h0, 32'h0,        1'b1);
        add("st_mis_12",    1'b1, 32'h12,   32'h55555555, 4'hF, 32'h0,        1'b1);
        add("ld_10_mis",    1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0);
        add("st_full_14",   1'b1, 32'h14,   32'h01234567, 4'hF, 32'h0,        1'b0);
        add("st_beA_14",    1'b1, 32'h14,   32'hA5A5A5A5, 4'hA, 32'h0,        1'b0);
        add("ld_14",        1'b0, 32'h14,   32'h0,        4'h0, 32'hA523A567, 1'b0);
        add("st_top_ffc",   1'b1, 32'hFFC,  32'h89ABCDEF, 4'hF, 32'h0,        1'b0);
        add("ld_top_ffc",   1'b0, 32'hFFC,  32'h0,        4'h0, 32'h89ABCDEF, 1'b0);
        add("st_zero_0",    1'b1, 32'h0,    32'h00000000, 4'hF, 32'h0,        1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        add("st_oob_1000",  1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1);
        add("ld_0_after",   1'b0, 32'h0,    32'h0,        4'h0, 32'h00000000, 1'b0);
        add("ld_oob_1000",  1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1);
`else
        add("st_wrap_1000", 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
        add("ld_0_after",   1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
        add("ld_wrap_1000", 1'b0, 32'h1000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
`endif

        for (int i = 0; i < nvec; i++) begin
            txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
        end

        // Backpressure: load 0x10 with rsp_ready low for 5 cycles
        req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0;
        rsp_ready[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk); #1; req_valid[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 40);
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata[0], 32'hDE22BE44);
            chk("bp_rsp_err",   32'(rsp_err[0]), 32'd0);
            chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1; rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_rel_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("bp_rel_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("bp_rel_req_ready", 32'(req_ready[0]), 32'd1);

        // Asynchronous reset mid-cycle while a response is pending
        rsp_ready[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk); #1; req_valid[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 40);
        chk("ar_pre_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        #2; rst_n[0] = 1'b0; #1;
        chk("ar_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("ar_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("ar_req_ready", 32'(req_ready[0]), 32'd0);
        chk("ar_rsp_err",   32'(rsp_err[0]), 32'd0);
        @(negedge clk); rst_n[0] = 1'b1;
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("ar_mem_kept", rd, 32'hDE22BE44);

        // LATENCY=0 instance
        txn(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd, er, lat);
        chk("l0_st_lat", 32'(lat), 32'd1);
        chk("l0_st_err", 32'(er), 32'd0);
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        chk("l0_ld_lat", 32'(lat), 32'd1);
        chk("l0_ld_rdata", rd, 32'h0BADF00D);
        txn(1, 1'b0, 32'h41, 32'h0, 4'h0, rd, er, lat);
        chk("l0_mis_err", 32'(er), 32'd1);
        chk("l0_mis_rdata", rd, 32'd0);

        // LATENCY=4 instance: reset during WAIT discards a store
        txn(2, 1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
        chk("l4_st_lat", 32'(lat), 32'd5);
        req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'hFFFFFFFF;
        req_be[2] = 4'hF; req_valid[2] = 1'b1;
        @(posedge clk); #1; req_valid[2] = 1'b0;
        @(negedge clk);
        chk("l4_in_wait", 32'(dbg_state[2]), 32'd1);
        @(negedge clk);
        #2; rst_n[2] = 1'b0; #1;
        chk("l4_rst_state", 32'(dbg_state[2]), 32'd0);
        @(negedge clk); rst_n[2] = 1'b1;
        repeat (6) @(negedge clk);
        txn(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("l4_word_unchanged", rd, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
